// File: rtl/can_clic_core.sv
// can_clic_core: core-local interrupt selector.
// Samples a packed array of {level, pending} entries. Registers an
// "interrupt present" flag and the index of the highest-level pending entry.
// On equal levels, the lowest index wins.
module can_clic_core #(
    parameter int NUM_ENTRIES = 2,
    parameter int ENTRY_W     = 3,
    parameter int INDEX_W     = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_ENTRIES-1:0][ENTRY_W-1:0]  entries,
    output logic                                 is_interrupt,
    output logic [INDEX_W-1:0]                   index
);

    localparam int LVL_W = ENTRY_W - 1;

    logic               is_interrupt_q, is_interrupt_d;
    logic [INDEX_W-1:0] index_q, index_d;
    logic [LVL_W-1:0]   win_lvl;

    // Linear scan from entry 0 upward. A later entry replaces the current
    // winner only when its level is strictly greater, so ties keep the lower
    // index. The first pending entry always takes over, even at level 0.
    always_comb begin
        is_interrupt_d = 1'b0;
        index_d        = '0;
        win_lvl        = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (entries[i][0] &&
                (!is_interrupt_d || (entries[i][ENTRY_W-1:1] > win_lvl))) begin
                is_interrupt_d = 1'b1;
                index_d        = INDEX_W'(i);
                win_lvl        = entries[i][ENTRY_W-1:1];
            end
        end
    end

    // Output registers. Reset takes priority over sampling.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_interrupt_q <= 1'b0;
            index_q        <= '0;
        end else begin
            is_interrupt_q <= is_interrupt_d;
            index_q        <= index_d;
        end
    end

    assign is_interrupt = is_interrupt_q;
    assign index        = index_q;

endmodule

// File: tb/tb_can_clic_core.sv
// Directed testbench for can_clic_core using the default parameters
// (2 entries, 3 bits per entry, 2-bit index).
module tb_can_clic_core;

    logic            clk;
    logic            reset;
    logic [1:0][2:0] entries;
    logic            is_interrupt;
    logic [1:0]      index;

    int total = 0;
    int bad   = 0;

    can_clic_core #(.NUM_ENTRIES(2), .ENTRY_W(3), .INDEX_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .entries      (entries),
        .is_interrupt (is_interrupt),
        .index        (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive entries at the falling edge, then sample just after the next rising edge.
    task automatic apply(input logic [5:0] e);
        @(negedge clk);
        entries = e;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic irq, input logic [1:0] idx);
        chk({tag, ".irq"}, 32'(is_interrupt), 32'(irq));
        chk({tag, ".idx"}, 32'(index), 32'(idx));
    endtask

    initial begin
        reset   = 1'b1;
        entries = {3'b000, 3'b001};

        // Reset held for two edges with entry 0 pending
        @(posedge clk); #1;
        expect_out("rst1", 1'b0, 2'd0);
        @(posedge clk); #1;
        expect_out("rst2", 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        expect_out("rel", 1'b1, 2'd0);

        // Single pending entry
        apply({3'b000, 3'b001});
        expect_out("single0", 1'b1, 2'd0);
        apply({3'b001, 3'b000});
        expect_out("single1", 1'b1, 2'd1);

        // Level bits set but nothing pending
        apply({3'b110, 3'b010});
        expect_out("idle_lvl", 1'b0, 2'd0);
        apply({3'b000, 3'b000});
        expect_out("idle_zero", 1'b0, 2'd0);

        // Priority ordering
        apply({3'b101, 3'b011});
        expect_out("prio_hi1", 1'b1, 2'd1);
        apply({3'b011, 3'b101});
        expect_out("prio_hi0", 1'b1, 2'd0);

        // A high level without pending loses to a pending level-0 entry
        apply({3'b110, 3'b001});
        expect_out("np_hilvl", 1'b1, 2'd0);
        apply({3'b001, 3'b110});
        expect_out("np_hilvl_sw", 1'b1, 2'd1);

        // Ties go to the lower index
        apply({3'b111, 3'b111});
        expect_out("tie3", 1'b1, 2'd0);
        apply({3'b001, 3'b001});
        expect_out("tie0", 1'b1, 2'd0);

        // Latency: no combinational path, the change shows one edge later
        apply({3'b000, 3'b001});
        expect_out("lat_pre", 1'b1, 2'd0);
        @(negedge clk);
        entries = {3'b001, 3'b000};
        #1;
        expect_out("lat_nocomb", 1'b1, 2'd0);
        @(posedge clk); #1;
        expect_out("lat_post", 1'b1, 2'd1);

        // Stable inputs hold stable outputs
        @(posedge clk); #1;
        expect_out("stable", 1'b1, 2'd1);

        // Mid-run reset for one cycle
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        expect_out("mid_rst", 1'b0, 2'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        expect_out("mid_rel", 1'b1, 2'd1);

        // A pending bit toggling every cycle is tracked edge by edge
        apply({3'b000, 3'b011});
        expect_out("tog_a", 1'b1, 2'd0);
        apply({3'b000, 3'b010});
        expect_out("tog_b", 1'b0, 2'd0);
        apply({3'b000, 3'b011});
        expect_out("tog_c", 1'b1, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
